// File: rtl/fifo_ctrl_tp.sv
// Synchronous FIFO controller driving an external two-port RAM with 1-cycle registered read.
// Latency: push visible in status next cycle; popped data valid (rd_valid) one cycle after pop.
// Backpressure: pushes rejected while full, pops rejected while empty; no bypass either way.
// Optional error flags (overflow/underflow/err_clr) are enabled by defining FIFO_ERR_FLAG_EN.
module fifo_ctrl_tp #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_rden,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef FIFO_ERR_FLAG_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  // Pointers carry an extra wrap bit above the RAM address bits.
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          push_ok, pop_ok;

  // Status, accept decisions and RAM strobes, all from pre-edge pointer state.
  always_comb begin
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                  (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
    count       = wptr_q - rptr_q;
    push_ok     = wr_en & ~full;
    pop_ok      = rd_en & ~empty;
    ram_wren    = push_ok;
    ram_wr_addr = wptr_q[ADDR_WIDTH-1:0];
    ram_data    = wr_data;
    ram_rden    = pop_ok;
    ram_rd_addr = rptr_q[ADDR_WIDTH-1:0];
    rd_data     = ram_q;
    rd_valid    = rd_valid_q;
  end

  // Next-state: advance pointers on accepted requests; rd_valid tracks the RAM read latency.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = pop_ok;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop_ok)  rptr_d = rptr_q + PW'(1);
  end

  // Pointer and valid registers; a read launched during reset is never reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    overflow_d  = (wr_en & full)  | (overflow_q  & ~err_clr);
    underflow_d = (rd_en & empty) | (underflow_q & ~err_clr);
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

  // Error flag registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_tp.sv
// Table-driven bench for fifo_ctrl_tp (ADDR_WIDTH=2) with a RAM model and a data scoreboard.
module tb_fifo_ctrl_tp;

  localparam int AW = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic          full, empty, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          ram_wren, ram_rden;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_data, ram_q;
`ifdef FIFO_ERR_FLAG_EN
  logic          err_clr, overflow, underflow;
`endif

  fifo_ctrl_tp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .count(count),
    .ram_wren(ram_wren), .ram_wr_addr(ram_wr_addr), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_rd_addr(ram_rd_addr), .ram_q(ram_q)
`ifdef FIFO_ERR_FLAG_EN
    , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // Two-port RAM model with 1-cycle registered read.
  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_wr_addr] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_rd_addr];
    else          ram_q <= 'x;
  end

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] wdat;
    logic          ewren;
    logic [AW-1:0] ewa;
    logic          erden;
    logic [AW-1:0] era;
    logic [AW:0]   ecnt;
    logic          efull;
    logic          eempty;
    logic          eovf;
    logic          eunf;
  } vec_t;

  vec_t          tv [$];
  logic [DW-1:0] sb [$];
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic vec_t mk(logic wr, logic rd, logic [DW-1:0] wdat,
                              logic ewren, logic [AW-1:0] ewa, logic erden, logic [AW-1:0] era,
                              logic [AW:0] ecnt, logic efull, logic eempty, logic eovf, logic eunf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wdat = wdat;
    v.ewren = ewren; v.ewa = ewa; v.erden = erden; v.era = era;
    v.ecnt = ecnt; v.efull = efull; v.eempty = eempty; v.eovf = eovf; v.eunf = eunf;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // After an edge: rd_valid must match the expected pop and data must match the scoreboard.
  task automatic chk_read(logic exp_valid);
    chk("rd_valid", 64'(rd_valid), 64'(exp_valid));
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_data: rd_valid with no expected entry, got %0h", rd_data);
      end else begin
        chk("rd_data", 64'(rd_data), 64'(sb.pop_front()));
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
`ifdef FIFO_ERR_FLAG_EN
    err_clr = 1'b0;
`endif
    //     wr rd data          wren wa rden ra cnt full empty ovf unf
    tv.push_back(mk(1, 0, 32'hA0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 32'hA1, 1, 1, 0, 0, 2, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 32'hA2, 1, 2, 0, 0, 3, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 32'hA3, 1, 3, 0, 0, 4, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 32'hA4, 0, 0, 0, 0, 4, 1, 0, 1, 0));  // overflow
    tv.push_back(mk(0, 1, 32'h0,  0, 0, 1, 0, 3, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 32'h0,  0, 0, 1, 1, 2, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 32'h0,  0, 0, 1, 2, 1, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 32'h0,  0, 0, 1, 3, 0, 0, 1, 1, 0));
    tv.push_back(mk(0, 1, 32'h0,  0, 0, 0, 0, 0, 0, 1, 1, 1));  // underflow
    // interleaved 6 push / 6 pop across the address wrap
    tv.push_back(mk(1, 0, 32'hB0, 1, 0, 0, 0, 1, 0, 0, 1, 1));
    tv.push_back(mk(1, 1, 32'hB1, 1, 1, 1, 0, 1, 0, 0, 1, 1));
    tv.push_back(mk(1, 1, 32'hB2, 1, 2, 1, 1, 1, 0, 0, 1, 1));
    tv.push_back(mk(1, 1, 32'hB3, 1, 3, 1, 2, 1, 0, 0, 1, 1));
    tv.push_back(mk(1, 1, 32'hB4, 1, 0, 1, 3, 1, 0, 0, 1, 1));
    tv.push_back(mk(1, 1, 32'hB5, 1, 1, 1, 0, 1, 0, 0, 1, 1));
    tv.push_back(mk(0, 1, 32'h0,  0, 0, 1, 1, 0, 0, 1, 1, 1));
    // simultaneous push/pop at count 0, 2 and 4
    tv.push_back(mk(1, 1, 32'hC0, 1, 2, 0, 0, 1, 0, 0, 1, 1));
    tv.push_back(mk(1, 0, 32'hC1, 1, 3, 0, 0, 2, 0, 0, 1, 1));
    tv.push_back(mk(1, 1, 32'hC2, 1, 0, 1, 2, 2, 0, 0, 1, 1));
    tv.push_back(mk(1, 0, 32'hC3, 1, 1, 0, 0, 3, 0, 0, 1, 1));
    tv.push_back(mk(1, 0, 32'hC4, 1, 2, 0, 0, 4, 1, 0, 1, 1));
    tv.push_back(mk(1, 1, 32'hC5, 0, 0, 1, 3, 3, 0, 0, 1, 1));
    tv.push_back(mk(0, 1, 32'h0,  0, 0, 1, 0, 2, 0, 0, 1, 1));
    tv.push_back(mk(0, 1, 32'h0,  0, 0, 1, 1, 1, 0, 0, 1, 1));
    tv.push_back(mk(1, 0, 32'hD0, 1, 3, 0, 0, 2, 0, 0, 1, 1));
    tv.push_back(mk(1, 0, 32'hD1, 1, 0, 0, 0, 3, 0, 0, 1, 1));
    tv.push_back(mk(1, 1, 32'hD2, 1, 1, 1, 2, 3, 0, 0, 1, 1));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_ram_wren", 64'(ram_wren), 64'd0);
    chk("rst_ram_rden", 64'(ram_rden), 64'd0);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      wr_en = tv[i].wr; rd_en = tv[i].rd; wr_data = tv[i].wdat;
      #1;
      chk($sformatf("v%0d_ram_wren", i), 64'(ram_wren), 64'(tv[i].ewren));
      if (tv[i].ewren) begin
        chk($sformatf("v%0d_ram_wr_addr", i), 64'(ram_wr_addr), 64'(tv[i].ewa));
        chk($sformatf("v%0d_ram_data", i), 64'(ram_data), 64'(tv[i].wdat));
        sb.push_back(tv[i].wdat);
      end
      chk($sformatf("v%0d_ram_rden", i), 64'(ram_rden), 64'(tv[i].erden));
      if (tv[i].erden)
        chk($sformatf("v%0d_ram_rd_addr", i), 64'(ram_rd_addr), 64'(tv[i].era));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 64'(count), 64'(tv[i].ecnt));
      chk($sformatf("v%0d_full", i), 64'(full), 64'(tv[i].efull));
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(tv[i].eempty));
      chk_read(tv[i].erden);
`ifdef FIFO_ERR_FLAG_EN
      chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(tv[i].eovf));
      chk($sformatf("v%0d_underflow", i), 64'(underflow), 64'(tv[i].eunf));
`endif
    end

`ifdef FIFO_ERR_FLAG_EN
    // err_clr alone clears both sticky flags
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_underflow", 64'(underflow), 64'd0);
    chk_read(1'b0);
    // set overflow again so reset has something to clear
    @(negedge clk);
    wr_en = 1'b1; wr_data = 32'hE0;
    sb.push_back(32'hE0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("refill_count", 64'(count), 64'd4);
    chk_read(1'b0);
    @(negedge clk);
    wr_en = 1'b1; err_clr = 1'b1;   // new error wins over clear
    @(posedge clk);
    #1;
    wr_en = 1'b0; err_clr = 1'b0;
    chk("clr_vs_err_overflow", 64'(overflow), 64'd1);
    chk_read(1'b0);
    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("pop_before_rst_count", 64'(count), 64'd3);
    chk_read(1'b1);
`endif

    // Reset while count=3 with a pop launched in the reset cycle
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rst = 1'b1;
    #1;
    chk("rstpop_count_pre", 64'(count), 64'd3);
    chk("rstpop_ram_rden", 64'(ram_rden), 64'd1);
    @(posedge clk);
    #1;
    sb.delete();
    chk("rstpop_count", 64'(count), 64'd0);
    chk("rstpop_empty", 64'(empty), 64'd1);
    chk("rstpop_full", 64'(full), 64'd0);
    chk("rstpop_rd_valid", 64'(rd_valid), 64'd0);
`ifdef FIFO_ERR_FLAG_EN
    chk("rstpop_overflow", 64'(overflow), 64'd0);
    chk("rstpop_underflow", 64'(underflow), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("post_rst_empty", 64'(empty), 64'd1);

    // After reset the FIFO restarts at address 0
    @(negedge clk);
    wr_en = 1'b1; wr_data = 32'hF0;
    #1;
    chk("post_rst_wr_addr", 64'(ram_wr_addr), 64'd0);
    sb.push_back(32'hF0);
    @(posedge clk);
    #1;
    chk_read(1'b0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1;
    #1;
    chk("post_rst_rd_addr", 64'(ram_rd_addr), 64'd0);
    @(posedge clk);
    #1;
    chk_read(1'b1);
    rd_en = 1'b0;
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
